// File: rtl/digit_serial_add_sub_pkg.sv
// digit_serial_pkg: shared op encoding and a gate-level full adder
package digit_serial_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction
endpackage

// File: rtl/digit_serial_add_sub_if.sv
// digit_serial_add_sub_if: digit stream bus; out_ovf exists only with DIGIT_SERIAL_OVF_EN
interface digit_serial_add_sub_if #(parameter int DIGIT_W = 1);
  logic in_valid;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic sub;
  logic flush;
  logic out_valid;
  logic [DIGIT_W-1:0] out_sum;
  logic out_last;
  logic out_carry;
`ifdef DIGIT_SERIAL_OVF_EN
  logic out_ovf;
`endif
  modport master (
    output in_valid, a, b, sub, flush,
    input out_valid, out_sum, out_last, out_carry
`ifdef DIGIT_SERIAL_OVF_EN
    , input out_ovf
`endif
  );
  modport slave (
    input in_valid, a, b, sub, flush,
    output out_valid, out_sum, out_last, out_carry
`ifdef DIGIT_SERIAL_OVF_EN
    , output out_ovf
`endif
  );
endinterface

// File: rtl/digit_serial_add_sub_ripple.sv
// digit_ripple_adder: combinational DIGIT_W-bit ripple of full adders
module digit_ripple_adder
  import digit_serial_pkg::*;
#(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co,
  output logic               c_msb_in
);
  logic [DIGIT_W:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fa
    assign {c[i+1], s[i]} = full_add(a[i], b[i], c[i]);
  end
  assign co = c[DIGIT_W];
  assign c_msb_in = c[DIGIT_W-1];
endmodule

// File: rtl/digit_serial_add_sub.sv
// digit_serial_add_sub: digit-serial add/subtract, LSB digit first; out_ovf with DIGIT_SERIAL_OVF_EN
module digit_serial_add_sub
  import digit_serial_pkg::*;
#(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 8
) (
  input logic clk,
  input logic rst,
  digit_serial_add_sub_if.slave bus
);
  localparam int CW = WORD_DIGITS > 1 ? $clog2(WORD_DIGITS) : 1;
  logic [CW-1:0] cnt;
  logic carry;
  op_e op_q;
  logic first, last, take, ci, co, c_msb;
  op_e op;
  logic [DIGIT_W-1:0] b_x, s;
  assign first = cnt == '0;
  assign last = cnt == CW'(WORD_DIGITS - 1);
  assign take = bus.in_valid & ~bus.flush;
  assign op = first ? op_e'(bus.sub) : op_q;
  assign ci = first ? bus.sub : carry;
  assign b_x = bus.b ^ {DIGIT_W{op == OP_SUB}};
  digit_ripple_adder #(.DIGIT_W(DIGIT_W)) u_add (
    .a(bus.a),
    .b(b_x),
    .ci(ci),
    .s(s),
    .co(co),
    .c_msb_in(c_msb)
  );
  // word framing: digit counter, inter-digit carry and the op latched on the first digit
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      cnt <= '0;
      carry <= 1'b0;
      if (rst) op_q <= OP_ADD;
    end else if (bus.in_valid) begin
      cnt <= last ? '0 : cnt + CW'(1);
      carry <= co;
      op_q <= op;
    end
  end
  // registered outputs; the sum digit holds across idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_sum <= '0;
      bus.out_last <= 1'b0;
      bus.out_carry <= 1'b0;
    end else begin
      bus.out_valid <= take;
      bus.out_last <= take & last;
      bus.out_carry <= take & last & co;
      if (take) bus.out_sum <= s;
    end
  end
`ifdef DIGIT_SERIAL_OVF_EN
  // signed overflow: carry into the word MSB differs from carry out of it
  always_ff @(posedge clk) bus.out_ovf <= rst ? 1'b0 : take & last & (c_msb ^ co);
`endif
endmodule

// File: tb/tb_digit_serial_add_sub.sv
// tb_digit_serial_add_sub: word-level model checked against the digit stream every cycle
module tb_digit_serial_add_sub;
  localparam int K_NONE = 0, K_IDLE = 1, K_VALID = 2, K_FLUSH = 3, K_RST = 4;
  typedef struct {logic s; logic l; logic c; logic o;} exp_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  digit_serial_add_sub_if #(.DIGIT_W(1)) bus1 ();
  digit_serial_add_sub_if #(.DIGIT_W(4)) bus2 ();
  digit_serial_add_sub #(.DIGIT_W(1), .WORD_DIGITS(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  digit_serial_add_sub #(.DIGIT_W(4), .WORD_DIGITS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  int checks = 0, errors = 0;
  int kind = K_NONE;
  int didx = 0;
  exp_t exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] acc_w = '0;
  logic last_sum = 1'b0;
  logic [7:0] m_res;
  logic m_c, m_o;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // whole-word arithmetic: {carry, signed overflow, result}
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [7:0] bm;
    logic [8:0] f;
    bm = s ? ~b : b;
    f = {1'b0, a} + {1'b0, bm} + 9'(s);
    return {f[8], (a[7] == bm[7]) && (f[7] != a[7]), f[7:0]};
  endfunction
  task automatic cyc(input logic v, input logic ai, input logic bi, input logic si, input logic fl, input logic r);
    bus1.in_valid = v;
    bus1.a = ai;
    bus1.b = bi;
    bus1.sub = si;
    bus1.flush = fl;
    rst = r;
    @(posedge clk);
    if (r) begin
      kind = K_RST;
      didx = 0;
    end else if (fl) begin
      kind = K_FLUSH;
      didx = 0;
    end else if (v) begin
      kind = K_VALID;
      exp_q.push_back('{m_res[didx], didx == 7, didx == 7 && m_c, didx == 7 && m_o});
      didx = didx == 7 ? 0 : didx + 1;
    end else kind = K_IDLE;
    #1;
  endtask
  task automatic send_word(input logic [7:0] a, input logic [7:0] b, input logic s, input int nd, input bit gaps);
    {m_c, m_o, m_res} = model(a, b, s);
    for (int k = 0; k < nd; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      cyc(1, a[k], b[k], k == 0 ? s : 1'($urandom), 0, 0);
    end
  endtask
  task automatic expect_word(input string name, input logic [7:0] val);
    if (got_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no word expected %0h", name, val);
    end else chk(name, got_q.pop_front(), val);
  endtask
  // per-cycle compare of dut1 against the model's expectation for the previous edge
  always @(negedge clk) begin
    exp_t e;
    case (kind)
      K_VALID: begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL exp_underrun: got out_valid %0b expected no pending digit", bus1.out_valid);
        end else begin
          e = exp_q.pop_front();
          chk("out_valid", bus1.out_valid, 1);
          chk("out_sum", bus1.out_sum, e.s);
          chk("out_last", bus1.out_last, e.l);
          chk("out_carry", bus1.out_carry, e.c);
`ifdef DIGIT_SERIAL_OVF_EN
          chk("out_ovf", bus1.out_ovf, e.o);
`endif
          last_sum = bus1.out_sum;
          acc_w = {bus1.out_sum, acc_w[7:1]};
          if (e.l) got_q.push_back(acc_w);
        end
      end
      K_IDLE: begin
        chk("idle_valid", bus1.out_valid, 0);
        chk("idle_last", bus1.out_last, 0);
        chk("idle_sum_hold", bus1.out_sum, last_sum);
      end
      K_FLUSH: begin
        chk("flush_valid", bus1.out_valid, 0);
        chk("flush_last", bus1.out_last, 0);
      end
      K_RST: begin
        chk("rst_valid", bus1.out_valid, 0);
        chk("rst_sum", bus1.out_sum, 0);
        chk("rst_last", bus1.out_last, 0);
        chk("rst_carry", bus1.out_carry, 0);
`ifdef DIGIT_SERIAL_OVF_EN
        chk("rst_ovf", bus1.out_ovf, 0);
`endif
        last_sum = 1'b0;
      end
      default: ;
    endcase
  end
  initial begin
    logic [7:0] ta[6], tb[6];
    logic ts[6];
    bus2.in_valid = 1'b0;
    bus2.a = '0;
    bus2.b = '0;
    bus2.sub = 1'b0;
    bus2.flush = 1'b0;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("model_5a_27", 32'(model(8'h5A, 8'h27, 1'b0)), {22'd0, 1'b0, 1'b1, 8'h81});
    chk("model_10_20", 32'(model(8'h10, 8'h20, 1'b1)), {22'd0, 1'b0, 1'b0, 8'hF0});
    chk("model_20_10", 32'(model(8'h20, 8'h10, 1'b1)), {22'd0, 1'b1, 1'b0, 8'h10});
    send_word(8'h5A, 8'h27, 1'b0, 8, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_word("w_5a_add_27", 8'h81);
    send_word(8'h10, 8'h20, 1'b1, 8, 1'b0);
    send_word(8'h20, 8'h10, 1'b1, 8, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_word("w_10_sub_20", 8'hF0);
    expect_word("w_20_sub_10", 8'h10);
    send_word(8'h5A, 8'h27, 1'b0, 8, 1'b1);
    cyc(0, 0, 0, 0, 0, 0);
    expect_word("w_gaps_5a_27", 8'h81);
    ta = '{8'hFF, 8'h7F, 8'h80, 8'h00, 8'hC3, 8'h55};
    tb = '{8'h01, 8'h01, 8'h01, 8'h00, 8'hC3, 8'hAA};
    ts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 6; t++) send_word(ta[t], tb[t], ts[t], 8, 1'b1);
    cyc(0, 0, 0, 0, 0, 0);
    expect_word("w_ff_add_01", 8'h00);
    expect_word("w_7f_add_01", 8'h80);
    expect_word("w_80_sub_01", 8'h7F);
    expect_word("w_00_sub_00", 8'h00);
    expect_word("w_c3_sub_c3", 8'h00);
    expect_word("w_55_add_aa", 8'hFF);
    send_word(8'hFF, 8'hFF, 1'b0, 3, 1'b0);
    cyc(1, 1, 1, 0, 1, 0);
    send_word(8'h01, 8'h01, 1'b0, 8, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_word("w_after_flush", 8'h02);
    send_word(8'h00, 8'hFF, 1'b1, 4, 1'b0);
    cyc(1, 1, 1, 1, 0, 1);
    send_word(8'h01, 8'h03, 1'b0, 8, 1'b0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_word("w_after_rst", 8'h04);
    bus2.in_valid = 1'b1;
    bus2.a = 4'hF;
    bus2.b = 4'h1;
    bus2.sub = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    chk("w4_d0_valid", bus2.out_valid, 1);
    chk("w4_d0_sum", bus2.out_sum, 4'h0);
    chk("w4_d0_last", bus2.out_last, 0);
    chk("w4_d0_carry", bus2.out_carry, 0);
    bus2.a = 4'hF;
    bus2.b = 4'h0;
    bus2.sub = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    bus2.in_valid = 1'b0;
    chk("w4_d1_valid", bus2.out_valid, 1);
    chk("w4_d1_sum", bus2.out_sum, 4'h0);
    chk("w4_d1_last", bus2.out_last, 1);
    chk("w4_d1_carry", bus2.out_carry, 1);
`ifdef DIGIT_SERIAL_OVF_EN
    chk("w4_d1_ovf", bus2.out_ovf, 0);
`endif
    cyc(0, 0, 0, 0, 0, 0);
    chk("w4_idle_valid", bus2.out_valid, 0);
    chk("w4_idle_last", bus2.out_last, 0);
    @(negedge clk);
    #1;
    kind = K_NONE;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("got_q_drained", got_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
